// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  localparam int DEF_BIN_W  = 16;
  localparam int DEF_DIGITS = 5;

  // Counter must be able to hold BIN_W itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) dout = din + ADJ_ADD;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// state | meaning
// IDLE  | waiting for start, bcd holds last result
// SHIFT | adjusting and shifting, one bit per edge
// DONE  | one-cycle done pulse, bcd just updated
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;

  logic [BCD_W-1:0]    adj_bcd;
  logic [WORK_W-1:0]   adj_work;
  logic [WORK_W-1:0]   shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work_q[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .dout (adj_bcd[DIGIT_W*g +: DIGIT_W])
    );
  end

  // Adjust all digits first, then shift the whole register by one.
  assign adj_work = {adj_bcd, work_q[BIN_W-1:0]};
  assign shifted  = {adj_work[WORK_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bcd_d   = shifted[WORK_W-1:BIN_W];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int total = 0;
  int bad   = 0;
  logic [19:0] prev_bcd = '0;

  bin2bcd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion with a one-cycle start; bin is scrambled after acceptance.
  task automatic convert(input logic [15:0] v, input string tag);
    int n;
    logic [19:0] exp;
    exp = to_bcd(v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'($urandom);
    n = 0;
    while (!done && n < 40) begin
      if (busy) n++;
      if (n == 8) chk({tag, "_hold_mid"}, 32'(bcd), 32'(prev_bcd));
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 16);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_bcd"}, 32'(bcd), 32'(exp));
    prev_bcd = exp;
    @(negedge clk);
    chk({tag, "_done_once"}, 32'({busy, done}), 0);
    chk({tag, "_bcd_held"}, 32'(bcd), 32'(exp));
  endtask

  // start held high; accept edges are predicted purely from the throughput rule.
  task automatic back_to_back(input bit rnd, input string tag);
    logic [15:0] vals[72];
    int pulses;
    int j;
    for (int k = 0; k < 72; k++)
      vals[k] = rnd ? 16'($urandom) : ((k % 2 == 0) ? 16'd100 : 16'd200);
    pulses = 0;
    for (int k = 0; k < 72; k++) begin
      bin   = vals[k];
      start = 1'b1;
      @(negedge clk);
      if (done) begin
        j = pulses;
        chk({tag, "_done_edge"}, k, 18*j + 16);
        if (18*j < 72) chk({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(vals[18*j])));
        pulses++;
      end
    end
    start = 1'b0;
    chk({tag, "_pulses"}, pulses, 4);
    prev_bcd = to_bcd(vals[54]);
    repeat (3) @(negedge clk);
    chk({tag, "_quiet"}, 32'({busy, done}), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_flags", 32'({busy, done}), 0);
    rst_n = 1'b1;
    bin   = 16'd777;
    repeat (5) @(negedge clk);
    chk("idle_quiet", 32'({busy, done}), 0);
    chk("idle_bcd", 32'(bcd), 0);

    convert(16'hFFFF, "max");
    convert(16'd0, "zero");
    convert(16'd9, "nine");
    convert(16'd10, "ten");
    convert(16'd12345, "d12345");
    for (int i = 0; i < 12; i++) convert(16'($urandom), "rand");

    back_to_back(1'b0, "b2b_toggle");
    back_to_back(1'b1, "b2b_rand");

    // Reset at the 8th busy cycle aborts the conversion.
    @(negedge clk);
    bin   = 16'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 8) begin
      if (busy) n++;
      if (n < 8) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 0);
    chk("abort_flags", 32'({busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("abort_no_done", n, 0);
    prev_bcd = '0;
    convert(16'd999, "after_abort");

    // start pulses in SHIFT and in DONE must be ignored.
    @(negedge clk);
    bin   = 16'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (busy) n++;
      if (n == 5) begin
        bin   = 16'd4321;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_busy_cycles", n, 16);
    chk("ign_bcd", 32'(bcd), 32'(to_bcd(1234)));
    bin   = 16'd777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_start", 32'({busy, done}), 0);
    repeat (3) @(negedge clk);
    chk("ign_no_restart", 32'({busy, done}), 0);
    chk("ign_bcd_held", 32'(bcd), 32'(to_bcd(1234)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
